onehot_decoder_seq: RTL and testbench

- Sequential 3-to-8 decoder; the inverse of the team's 8-to-3 LSB-priority encoder.
- Accepts binary codes over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives each decoded code as a one-hot word on out_onehot, held for a programmable number of cycles.
- Sits downstream of the encoder to regenerate one-hot selects/strobes from a compressed code stream.

---
 rtl/onehot_decoder_seq_pkg.sv | 31 +++
 rtl/onehot_decoder_seq_code_fifo2.sv | 62 ++++++
 rtl/onehot_decoder_seq.sv | 123 ++++++++++++
 tb/tb_onehot_decoder_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_seq_pkg.sv
// +--------------------------------------------------------------------+
// | onehot_decoder_seq_pkg : shared code/one-hot constants and types     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package onehot_decoder_seq_pkg;

  localparam int CODE_W     = 3;
  localparam int N_OUT      = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic              none;
    logic [CODE_W-1:0] code;
  } entry_t;

  // A "none" entry mirrors the encoder's no-bit-set result.
  function automatic logic [N_OUT-1:0] decode(input entry_t e);
    return e.none ? '0 : (N_OUT'(1) << e.code);
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder_seq_code_fifo2.sv
// +--------------------------------------------------------------------+
// | code_fifo2 : two-entry in-order FIFO of decoder entries              |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module code_fifo2
  import onehot_decoder_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  entry_t                wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output entry_t                head,
  output logic [FIFO_CNT_W-1:0] count
);

  entry_t                r_mem [FIFO_DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [FIFO_CNT_W-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
        2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
// +--------------------------------------------------------------------+
// | onehot_decoder_seq : buffered 3-to-8 decoder, each word held N cycles|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_none,
  output logic [N_OUT-1:0]  out_onehot,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [N_OUT-1:0]      r_onehot;
  logic [N_OUT-1:0]      w_onehot_next;
  logic                  r_valid;
  logic                  w_valid_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  entry_t                w_head;
  entry_t                w_wdata;
  logic [FIFO_CNT_W-1:0] w_count;

  assign w_push  = in_valid && in_ready;
  assign w_wdata = '{none: in_none, code: in_code};

  code_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_onehot <= w_onehot_next;
      r_valid  <= w_valid_next;
    end
  end

  // The last hold cycle doubles as a load slot so streams have no idle gap.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_onehot_next = r_onehot;
    w_valid_next  = r_valid;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_onehot_next = decode(w_head);
          w_valid_next  = 1'b1;
          w_cnt_next    = C_HOLD_LOAD;
          w_state_next  = HOLD;
        end else begin
          w_onehot_next = '0;
          w_valid_next  = 1'b0;
        end
      end
      HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else if (!w_empty) begin
          w_pop         = 1'b1;
          w_onehot_next = decode(w_head);
          w_valid_next  = 1'b1;
          w_cnt_next    = C_HOLD_LOAD;
        end else begin
          w_onehot_next = '0;
          w_valid_next  = 1'b0;
          w_state_next  = IDLE;
        end
      end
      default: begin
        w_onehot_next = '0;
        w_valid_next  = 1'b0;
        w_cnt_next    = '0;
        w_state_next  = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready   = !w_full;
    busy       = r_valid | !w_empty;
    out_onehot = r_onehot;
    out_valid  = r_valid;
  end

endmodule

`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: an entry-schedule reference model (accept/start
// times per entry) drives per-cycle expectations for HOLD_CYCLES=4 and =1 instances.
`default_nettype none

module tb_onehot_decoder_seq;

  localparam int MAXC = 300;
  localparam int MAXI = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v4, n4, r4, ov4, b4;
  logic [2:0] c4;
  logic [7:0] oh4;
  logic       v1, n1, r1, ov1, b1;
  logic [2:0] c1;
  logic [7:0] oh1;

  onehot_decoder_seq #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_code(c4),
    .in_none(n4), .out_onehot(oh4), .out_valid(ov4), .busy(b4)
  );

  onehot_decoder_seq #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_code(c1),
    .in_none(n1), .out_onehot(oh1), .out_valid(ov1), .busy(b1)
  );

  int errors = 0;
  int checks = 0;

  logic [2:0]  it_code [MAXI];
  bit          it_none [MAXI];
  int          it_gap  [MAXI];
  int          n_items;
  int          m_acc   [MAXI];
  int          m_start [MAXI];
  logic [10:0] obs     [MAXC];
  logic [10:0] expv    [MAXC];
  int          ncyc;
  logic [7:0]  lit     [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  function automatic logic [7:0] ref_word(input bit none, input logic [2:0] code);
    return none ? 8'h00 : 8'(1 << code);
  endfunction

  function automatic void set_item(input int i, input int code, input bit none, input int gap);
    it_code[i] = 3'(code);
    it_none[i] = none;
    it_gap[i]  = gap;
  endfunction

  // Entry i is accepted at the first offered edge where fewer than 2 entries wait,
  // and starts at max(accept+1, previous start + h); it is shown for h cycles.
  function automatic void build_model(input int h);
    int e, cnt, wordj;
    bit vld;
    logic [7:0] w;
    for (int i = 0; i < n_items; i++) begin
      e = (i == 0) ? it_gap[0] : m_acc[i-1] + 1 + it_gap[i];
      forever begin
        cnt = 0;
        for (int j = 0; j < i; j++) begin
          if (m_acc[j] <= e - 1) cnt++;
          if (m_start[j] <= e - 1) cnt--;
        end
        if (cnt < 2) break;
        e++;
      end
      m_acc[i]   = e;
      m_start[i] = (i == 0) ? e + 1 : ((e + 1 > m_start[i-1] + h) ? e + 1 : m_start[i-1] + h);
    end
    ncyc = m_start[n_items-1] + h + 3;
    if (ncyc > MAXC) ncyc = MAXC;
    for (int c = 0; c < ncyc; c++) begin
      cnt = 0;
      vld = 1'b0;
      w = 8'h00;
      wordj = -1;
      for (int j = 0; j < n_items; j++) begin
        if (m_acc[j] <= c) cnt++;
        if (m_start[j] <= c) cnt--;
        if (m_start[j] <= c && c < m_start[j] + h) wordj = j;
      end
      if (wordj >= 0) begin
        vld = 1'b1;
        w = ref_word(it_none[wordj], it_code[wordj]);
      end
      expv[c] = {w, vld, (vld || cnt != 0), (cnt != 2)};
    end
  endfunction

  // Producer offers items in order, holding each until the DUT's in_ready accepts it.
  task automatic run(input bit sel);
    int i = 0;
    int earliest = it_gap[0];
    bit offer, rdy;
    for (int c = 0; c < ncyc; c++) begin
      offer = (i < n_items) && (c >= earliest);
      if (sel) begin
        v1 = offer;
        c1 = offer ? it_code[i] : 3'($urandom);
        n1 = offer ? it_none[i] : 1'($urandom);
        if (offer && it_none[i]) c1 = 3'($urandom);
      end else begin
        v4 = offer;
        c4 = offer ? it_code[i] : 3'($urandom);
        n4 = offer ? it_none[i] : 1'($urandom);
        if (offer && it_none[i]) c4 = 3'($urandom);
      end
      rdy = sel ? r1 : r4;
      @(posedge clk);
      if (offer && rdy) begin
        i++;
        if (i < n_items) earliest = c + 1 + it_gap[i];
      end
      @(negedge clk);
      obs[c] = sel ? {oh1, ov1, b1, r1} : {oh4, ov4, b4, r4};
    end
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({oh4, ov4, b4, r4} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_h4: got onehot=%h valid=%b busy=%b ready=%b, expected 00 0 0 1", oh4, ov4, b4, r4);
    end
    checks++;
    if ({oh1, ov1, b1, r1} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_h1: got onehot=%h valid=%b busy=%b ready=%b, expected 00 0 0 1", oh1, ov1, b1, r1);
    end
  endtask

  task automatic test_single_codes();
    int hits;
    for (int k = 0; k < 8; k++) begin
      n_items = 1;
      set_item(0, k, 1'b0, 0);
      build_model(4);
      run(1'b0);
      hits = 0;
      for (int c = 0; c < ncyc; c++) begin
        checks++;
        if (obs[c] !== expv[c]) begin
          errors++;
          $display("FAIL single code=%0d cyc=%0d: got {oh,v,busy,rdy}=%h expected %h", k, c, obs[c], expv[c]);
        end
        if (obs[c][2] && obs[c][10:3] == lit[k]) hits++;
      end
      checks++;
      if (hits != 4) begin
        errors++;
        $display("FAIL single_width code=%0d: got %0d cycles of %h, expected 4", k, hits, lit[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcount;
    bit saw_full;
    n_items = 3;
    set_item(0, 2, 1'b0, 0);
    set_item(1, 7, 1'b0, 0);
    set_item(2, 0, 1'b0, 0);
    build_model(4);
    run(1'b0);
    vcount = 0;
    saw_full = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d: got {oh,v,busy,rdy}=%h expected %h", c, obs[c], expv[c]);
      end
      if (obs[c][2]) vcount++;
      if (!obs[c][0]) saw_full = 1'b1;
    end
    checks++;
    if (vcount != 12 || !saw_full) begin
      errors++;
      $display("FAIL back_to_back_totals: got valid_cycles=%0d full_seen=%b, expected 12 1", vcount, saw_full);
    end
  endtask

  task automatic test_none_entry();
    n_items = 3;
    set_item(0, 1, 1'b0, 0);
    set_item(1, 0, 1'b1, 0);
    set_item(2, 6, 1'b0, 0);
    build_model(4);
    run(1'b0);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL none_entry cyc=%0d: got {oh,v,busy,rdy}=%h expected %h", c, obs[c], expv[c]);
      end
    end
  endtask

  task automatic test_streaming();
    bit always_ready;
    n_items = 8;
    for (int k = 0; k < 8; k++) set_item(k, k, 1'b0, 0);
    build_model(1);
    run(1'b1);
    always_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs[c] !== expv[c]) begin
        errors++;
        $display("FAIL stream cyc=%0d: got {oh,v,busy,rdy}=%h expected %h", c, obs[c], expv[c]);
      end
      if (!obs[c][0]) always_ready = 1'b0;
    end
    checks++;
    if (!always_ready || obs[8][10:3] !== lit[7]) begin
      errors++;
      $display("FAIL stream_ready: got ready_always=%b last_word=%h, expected 1 80", always_ready, obs[8][10:3]);
    end
  endtask

  task automatic test_random();
    bit sel;
    for (int r = 0; r < 6; r++) begin
      sel = 1'($urandom);
      n_items = 10;
      for (int i = 0; i < n_items; i++)
        set_item(i, int'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0);
      build_model(sel ? 1 : 4);
      run(sel);
      for (int c = 0; c < ncyc; c++) begin
        checks++;
        if (obs[c] !== expv[c]) begin
          errors++;
          $display("FAIL random round=%0d h=%0d cyc=%0d: got %h expected %h", r, sel ? 1 : 4, c, obs[c], expv[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit leaked = 1'b0;
    v4 = 1'b1; n4 = 1'b0; c4 = 3'd3;
    @(posedge clk); @(negedge clk);
    c4 = 3'd4;
    @(posedge clk); @(negedge clk);
    c4 = 3'd5;
    @(posedge clk); @(negedge clk);
    v4 = 1'b0;
    checks++;
    if ({oh4, ov4, r4} !== {8'h08, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_pre: got onehot=%h valid=%b ready=%b, expected 08 1 0", oh4, ov4, r4);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({oh4, ov4, b4, r4} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_async: got onehot=%h valid=%b busy=%b ready=%b, expected 00 0 0 1", oh4, ov4, b4, r4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ov4 !== 1'b0 || oh4 !== 8'h00 || b4 !== 1'b0) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL reset_mid_flush: got stale entry output after reset, expected none");
    end
  endtask

  initial begin
    v4 = 1'b0; c4 = 3'd0; n4 = 1'b0;
    v1 = 1'b0; c1 = 3'd0; n1 = 1'b0;
    test_reset();
    test_single_codes();
    test_back_to_back();
    test_none_entry();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
